// File: rtl/pipe_stage_pkg.sv
// Shared types and sizing for the score/interval pipeline stages.
package pipe_stage_pkg;

    localparam int LANES = 4;
    localparam int PARA  = 16;
    localparam int N     = 4096;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_SKIP = 1'b1
    } stage4_state_e;

endpackage

// File: rtl/pipe_stage4_if.sv
// Handshake and payload bundle of the interval-miss tracker (slave = tracker side).
interface pipe_stage4_if #(
    parameter int PARA  = pipe_stage_pkg::PARA,
    parameter int IDX_W = pipe_stage_pkg::IDX_W
);
    import pipe_stage_pkg::*;

    logic                           valid_i;
    logic                           ready_o;
    logic [LANES-1:0]               out_of_mode_interval_i;
    logic [PARA-1:0]                thresh_i;
    logic                           clear_i;
    logic                           valid_o;
    logic                           ready_i;
    logic [LANES-1:0]               prune_o;
    logic                           all_pruned_o;
    logic [IDX_W-1:0]               token_idx_o;
    logic                           last_o;
    logic [LANES-1:0][PARA-1:0]     interval_cnt_o;

    modport slave (
        input  valid_i, out_of_mode_interval_i, thresh_i, clear_i, ready_i,
        output ready_o, valid_o, prune_o, all_pruned_o, token_idx_o, last_o,
               interval_cnt_o
    );

    modport master (
        output valid_i, out_of_mode_interval_i, thresh_i, clear_i, ready_i,
        input  ready_o, valid_o, prune_o, all_pruned_o, token_idx_o, last_o,
               interval_cnt_o
    );

endinterface

// File: rtl/lane_interval_counter.sv
// One lane's saturating miss run-length counter with sticky prune flag.
// pruned_o already includes the prune decision of the beat currently presented.
module lane_interval_counter #(
    parameter int PARA = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            en_i,
    input  logic            miss_i,
    input  logic [PARA-1:0] thresh_i,
    output logic [PARA-1:0] cnt_o,
    output logic            pruned_o
);

    localparam logic [PARA-1:0] CNT_MAX = '1;

    logic [PARA-1:0] cnt_q;
    logic [PARA-1:0] cnt_d;
    logic            pruned_q;
    logic            pruned_d;

    // Pruned lanes freeze; otherwise count misses (saturating) or restart on a hit.
    always_comb begin
        cnt_d    = cnt_q;
        pruned_d = pruned_q;
        if (pruned_q) begin
            cnt_d = cnt_q;
        end else if (miss_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PARA'(1);
        end else begin
            cnt_d = '0;
        end
        if ((thresh_i != '0) && (cnt_d >= thresh_i)) begin
            pruned_d = 1'b1;
        end else begin
            pruned_d = pruned_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q    <= '0;
            pruned_q <= 1'b0;
        end else if (en_i) begin
            cnt_q    <= cnt_d;
            pruned_q <= pruned_d;
        end else begin
            cnt_q    <= cnt_q;
            pruned_q <= pruned_q;
        end
    end

    assign cnt_o    = cnt_q;
    assign pruned_o = pruned_d;

endmodule

// File: rtl/pipe_stage4.sv
// Per-lane interval-miss tracker with lane pruning, early exit over fully
// pruned sequences, and a one-deep registered valid/ready output.
module pipe_stage4
    import pipe_stage_pkg::*;
#(
    parameter int P_PARA = PARA,
    parameter int P_N    = N
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pipe_stage4_if.slave  bus
);

    localparam int               P_IDX_W  = $clog2(P_N);
    localparam logic [P_IDX_W-1:0] IDX_LAST = P_IDX_W'(P_N - 1);

    stage4_state_e        state_q;
    logic [P_IDX_W-1:0]   idx_q;
    logic [P_IDX_W-1:0]   idx_d;
    logic                 valid_q;
    logic [LANES-1:0]     prune_q;
    logic                 all_q;
    logic [P_IDX_W-1:0]   tidx_q;
    logic                 last_q;

    logic                 ready;
    logic                 accept;
    logic                 is_last;
    logic                 lane_clear;
    logic [LANES-1:0]     mask_nxt;
    logic                 all_nxt;

    assign ready      = ~bus.clear_i & (~valid_q | bus.ready_i);
    assign accept     = bus.valid_i & ready;
    assign is_last    = (idx_q == IDX_LAST);
    // The sequence-end clear lands on the same edge the last beat is emitted.
    assign lane_clear = bus.clear_i | (accept & is_last);
    assign all_nxt    = &mask_nxt;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_interval_counter #(.PARA(P_PARA)) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear_i  (lane_clear),
            .en_i     (accept),
            .miss_i   (bus.out_of_mode_interval_i[g]),
            .thresh_i (bus.thresh_i),
            .cnt_o    (bus.interval_cnt_o[g]),
            .pruned_o (mask_nxt[g])
        );
    end

    always_comb begin
        idx_d = idx_q;
        if (bus.clear_i) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = is_last ? '0 : idx_q + P_IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Control FSM plus output register; an unaccepted pending beat survives clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            valid_q <= 1'b0;
            prune_q <= '0;
            all_q   <= 1'b0;
            tidx_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end
            if (bus.clear_i) begin
                state_q <= S_RUN;
            end else if (accept) begin
                case (state_q)
                    S_RUN: begin
                        valid_q <= 1'b1;
                        prune_q <= mask_nxt;
                        all_q   <= all_nxt;
                        tidx_q  <= idx_q;
                        last_q  <= is_last;
                        state_q <= (all_nxt && !is_last) ? S_SKIP : S_RUN;
                    end
                    S_SKIP: begin
                        if (is_last) begin
                            valid_q <= 1'b1;
                            prune_q <= '1;
                            all_q   <= 1'b1;
                            tidx_q  <= idx_q;
                            last_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_SKIP;
                        end
                    end
                    default: state_q <= S_RUN;
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign bus.ready_o      = ready;
    assign bus.valid_o      = valid_q;
    assign bus.prune_o      = prune_q;
    assign bus.all_pruned_o = all_q;
    assign bus.token_idx_o  = tidx_q;
    assign bus.last_o       = last_q;

endmodule

// File: tb/tb_pipe_stage4.sv
// Directed bench for pipe_stage4 (PARA=4) with a scoreboard of expected output beats.
module tb_pipe_stage4;

    localparam int PARA_T = 4;
    localparam int N_T    = 4096;
    localparam int CMAX   = 15;

    typedef struct packed {
        logic [3:0]  mask;
        logic        all;
        logic [11:0] idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage4_if #(.PARA(PARA_T), .IDX_W(12)) bus ();

    pipe_stage4 #(.P_PARA(PARA_T), .P_N(N_T)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int    n_pass  = 0;
    int    n_total = 0;
    int    n_emit  = 0;
    int    m_cnt [4];
    logic [3:0] m_pr = 4'b0000;
    int    m_idx  = 0;
    bit    m_skip = 1'b0;
    bit    mv     = 1'b0;
    beat_t q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_zero();
        for (int l = 0; l < 4; l++) m_cnt[l] = 0;
        m_pr  = 4'b0000;
        m_idx = 0;
        m_skip = 1'b0;
    endtask

    // One clock: check outputs against the model, advance the model, step the clock.
    task automatic cyc();
        beat_t b, e, nb;
        logic  mready, acc, last;
        #1;
        mready = !bus.clear_i && (!mv || bus.ready_i);
        chk("ready_o", bus.ready_o, mready);
        chk("valid_o", bus.valid_o, mv);
        if (mv) begin
            e = (q.size() > 0) ? q[0] : '0;
            b = {bus.prune_o, bus.all_pruned_o, bus.token_idx_o, bus.last_o};
            chk("beat", b, e);
            if (bus.ready_i) begin
                if (q.size() > 0) void'(q.pop_front());
                n_emit++;
            end
        end
        for (int l = 0; l < 4; l++) chk("cnt", bus.interval_cnt_o[l], m_cnt[l]);
        acc = bus.valid_i && mready;
        if (mv && bus.ready_i) mv = 1'b0;
        if (rst) begin
            model_zero();
            q.delete();
            mv = 1'b0;
        end else if (bus.clear_i) begin
            model_zero();
        end else if (acc) begin
            last = (m_idx == N_T - 1);
            for (int l = 0; l < 4; l++) begin
                if (!m_pr[l]) begin
                    if (bus.out_of_mode_interval_i[l]) m_cnt[l] = (m_cnt[l] == CMAX) ? CMAX : m_cnt[l] + 1;
                    else m_cnt[l] = 0;
                    if (bus.thresh_i != 4'd0 && m_cnt[l] >= int'(bus.thresh_i)) m_pr[l] = 1'b1;
                end
            end
            if (!m_skip) begin
                nb.mask = m_pr; nb.all = &m_pr; nb.idx = 12'(m_idx); nb.last = last;
                q.push_back(nb);
                mv = 1'b1;
                if (&m_pr && !last) m_skip = 1'b1;
            end else if (last) begin
                nb.mask = 4'hF; nb.all = 1'b1; nb.idx = 12'(m_idx); nb.last = 1'b1;
                q.push_back(nb);
                mv = 1'b1;
                m_skip = 1'b0;
            end
            m_idx = last ? 0 : m_idx + 1;
            if (last) begin
                for (int l = 0; l < 4; l++) m_cnt[l] = 0;
                m_pr = 4'b0000;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [3:0] miss);
        bus.valid_i = 1'b1;
        bus.out_of_mode_interval_i = miss;
        cyc();
    endtask

    task automatic idle();
        bus.valid_i = 1'b0;
        bus.out_of_mode_interval_i = 4'b0000;
        cyc();
    endtask

    task automatic clr();
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b1;
        cyc();
        bus.clear_i = 1'b0;
    endtask

    initial begin
        int e0;
        for (int l = 0; l < 4; l++) m_cnt[l] = 0;
        bus.valid_i = 1'b0;
        bus.out_of_mode_interval_i = 4'b0000;
        bus.thresh_i = 4'd3;
        bus.clear_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_prune", bus.prune_o, 4'b0000);
        chk("rst_all", bus.all_pruned_o, 1'b0);
        chk("rst_idx", bus.token_idx_o, 12'd0);
        chk("rst_last", bus.last_o, 1'b0);
        chk("rst_cnt", bus.interval_cnt_o, 16'h0000);
        rst = 1'b0;

        // misses to prune on lane 0
        beat(4'b0001); chk("p_cnt0_a", bus.interval_cnt_o[0], 4'd1);
        beat(4'b0001); chk("p_cnt0_b", bus.interval_cnt_o[0], 4'd2);
        beat(4'b0001); chk("p_cnt0_c", bus.interval_cnt_o[0], 4'd3);
        chk("p_prune_tok2", bus.prune_o, 4'b0001);
        chk("p_idx_tok2", bus.token_idx_o, 12'd2);
        chk("p_other_cnt", bus.interval_cnt_o[3:1], 12'h000);
        idle();
        clr();

        // run reset on lane 1
        beat(4'b0010); chk("r_cnt1_a", bus.interval_cnt_o[1], 4'd1);
        beat(4'b0010); chk("r_cnt1_b", bus.interval_cnt_o[1], 4'd2);
        beat(4'b0000); chk("r_cnt1_c", bus.interval_cnt_o[1], 4'd0);
        beat(4'b0010); chk("r_cnt1_d", bus.interval_cnt_o[1], 4'd1);
        chk("r_prune", bus.prune_o, 4'b0000);
        idle();
        clr();

        // back-pressure
        beat(4'b0000);
        bus.ready_i = 1'b0;
        repeat (4) beat(4'b0000);
        chk("bp_idx", bus.token_idx_o, 12'd0);
        chk("bp_ready", bus.ready_o, 1'b0);
        bus.ready_i = 1'b1;
        e0 = n_emit;
        repeat (6) beat(4'b0000);
        idle();
        chk("bp_count", n_emit - e0, 7);
        clr();

        // saturation with pruning disabled
        bus.thresh_i = 4'd0;
        repeat (20) beat(4'hF);
        chk("sat_cnt", bus.interval_cnt_o, 16'hFFFF);
        chk("sat_prune", bus.prune_o, 4'b0000);
        idle();
        clr();

        // clear with valid, then reset mid-stall
        repeat (100) beat(4'b0000);
        chk("cl_idx99", bus.token_idx_o, 12'd99);
        bus.clear_i = 1'b1;
        beat(4'b0000);
        bus.clear_i = 1'b0;
        beat(4'b0000);
        chk("cl_idx0", bus.token_idx_o, 12'd0);
        bus.ready_i = 1'b0;
        beat(4'b0000);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        bus.ready_i = 1'b1;
        chk("rs_valid", bus.valid_o, 1'b0);
        idle();

        // early exit
        bus.thresh_i = 4'd1;
        e0 = n_emit;
        repeat (5) beat(4'b0000);
        beat(4'hF);
        chk("ee_all5", bus.all_pruned_o, 1'b1);
        chk("ee_idx5", bus.token_idx_o, 12'd5);
        for (int t = 6; t < N_T; t++) beat(4'b0000);
        chk("ee_last", bus.last_o, 1'b1);
        chk("ee_idx_last", bus.token_idx_o, 12'd4095);
        chk("ee_mask_last", bus.prune_o, 4'hF);
        chk("ee_cnt_clr", bus.interval_cnt_o, 16'h0000);
        idle();
        chk("ee_count", n_emit - e0, 7);
        beat(4'b0000);
        chk("ee_wrap_idx", bus.token_idx_o, 12'd0);
        chk("ee_wrap_mask", bus.prune_o, 4'b0000);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
